// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-expansion sequencer: drives the single-round key datapath for 32 cycles and
// keeps the round keys in a flop file readable in forward or reversed order.
`timescale 1ns/1ps

module one_round_for_key_exp (
  input  logic [5:0]   count_round_in,
  input  logic [127:0] data_in,
  input  logic [31:0]  ck_parameter_in,
  output logic [127:0] result_out,
  output logic [31:0]  rk_o
);
  localparam logic [127:0] Fk = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [127:0] SboxRows [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    row = SboxRows[x[7:4]];
    // Column 0 is the most significant byte of each row.
    return row[{~x[3:0], 3'b000} +: 8];
  endfunction

  logic [127:0] k;
  logic [31:0]  t_in;
  logic [31:0]  t_sub;
  logic [31:0]  t_lin;

  // FK whitening is folded into the first round so the sequencer can load the raw key.
  assign k      = (count_round_in == 6'd1) ? (data_in ^ Fk) : data_in;
  assign t_in   = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_parameter_in;
  assign t_sub  = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
  assign t_lin  = t_sub ^ {t_sub[18:0], t_sub[31:19]} ^ {t_sub[8:0], t_sub[31:9]};
  assign rk_o   = k[127:96] ^ t_lin;
  assign result_out = {k[95:0], rk_o};
endmodule

module sm4_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [127:0] key_i,
  input  logic [4:0]   rk_addr_i,
  input  logic         decrypt_i,
  output logic [31:0]  rk_rdata_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         key_valid_o
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         key_valid_q, key_valid_d;
  logic         rk_we;
  logic [4:0]   rnd_idx;
  logic [7:0]   ck_base;
  logic [31:0]  ck;
  logic [31:0]  rk_new;
  logic [127:0] round_out;
  logic [31:0]  rk_file [32];

  assign rnd_idx = 5'(cnt_q - 6'd1);
  assign ck_base = {1'b0, rnd_idx, 2'b00};

  // CK byte j of round i is ((4i+j)*7) mod 256, MSB first.
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[8*(3-j) +: 8] = (ck_base + 8'(j)) * 8'd7;
    end
  end

  one_round_for_key_exp u_round (
    .count_round_in  (cnt_q),
    .data_in         (state_q),
    .ck_parameter_in (ck),
    .result_out      (round_out),
    .rk_o            (rk_new)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    rk_we       = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          state_d     = key_i;
          cnt_d       = 6'd1;
          key_valid_d = 1'b0;
          fsm_d       = StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          fsm_d = StIdle;
        end else begin
          rk_we   = 1'b1;
          state_d = round_out;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd32) begin
            fsm_d       = StDone;
            key_valid_d = 1'b1;
          end
        end
      end
      StDone: fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Round-key storage is intentionally not reset; it is only meaningful with key_valid_o.
  always_ff @(posedge clk) begin
    if (rk_we) begin
      rk_file[rnd_idx] <= rk_new;
    end
  end

  assign rk_rdata_o  = rk_file[decrypt_i ? ~rk_addr_i : rk_addr_i];
  assign busy_o      = (fsm_q == StRun);
  assign done_o      = (fsm_q == StDone);
  assign key_valid_o = key_valid_q;
endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Directed + random bench for sm4_key_sched_ctrl against a whole-schedule SM4 reference model.
`timescale 1ns/1ps

module tb_sm4_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         abort_i;
  logic [127:0] key_i;
  logic [4:0]   rk_addr_i;
  logic         decrypt_i;
  logic [31:0]  rk_rdata_o;
  logic         busy_o;
  logic         done_o;
  logic         key_valid_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] StdKey = 128'h0123456789abcdeffedcba9876543210;

  always #5 clk = ~clk;

  sm4_key_sched_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .key_i       (key_i),
    .rk_addr_i   (rk_addr_i),
    .decrypt_i   (decrypt_i),
    .rk_rdata_o  (rk_rdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .key_valid_o (key_valid_o)
  );

  logic [127:0] sbox_rows [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic [31:0] model_rk [32];
  logic [31:0] ck_seen [33];
  int          first_done, done_cnt, busy_cnt;
  logic        kv_at1, kv_at_done;
  logic [2:0]  snap;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    int           col;
    row = sbox_rows[x[7:4]];
    col = 15 - int'(x[3:0]);
    return row[8*col +: 8];
  endfunction

  function automatic logic [31:0] ck_of(input int i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*(3-j) +: 8] = 8'((4*i + j) * 7);
    return r;
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  task automatic model(input logic [127:0] key);
    logic [31:0] k [36];
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_of(i));
      model_rk[i] = k[i+4];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Start a run, then observe ncyc cycles (cycle 1 = first cycle after the accepting edge).
  task automatic run(input logic [127:0] key, input int ncyc, input int abort_at,
                     input int rst_at, input int restart_at, input logic [127:0] alt_key,
                     input int snap_at);
    start_i = 1'b1;
    key_i   = key;
    step();
    start_i    = 1'b0;
    key_i      = rand_key();
    first_done = 0;
    done_cnt   = 0;
    busy_cnt   = 0;
    kv_at1     = key_valid_o;
    kv_at_done = 1'b0;
    snap       = 3'b111;
    for (int c = 1; c <= ncyc; c++) begin
      if (busy_o) begin
        busy_cnt++;
        if (c <= 32) begin
          ck_seen[c] = dut.u_round.ck_parameter_in;
          check("ck_per_round", ck_seen[c], ck_of(c - 1));
        end
      end
      if (done_o) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = c;
          kv_at_done = key_valid_o;
        end
      end
      if (c == snap_at) snap = {busy_o, done_o, key_valid_o};
      abort_i = (c == abort_at);
      rst     = (c == rst_at);
      start_i = (c == restart_at);
      if (c == restart_at) key_i = alt_key;
      if (c < ncyc) step();
    end
    abort_i = 1'b0;
    rst     = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_table(input logic [127:0] key);
    model(key);
    for (int a = 0; a < 32; a++) begin
      step();
      rk_addr_i = 5'(a);
      decrypt_i = 1'b0;
      #1 check("rk_fwd", rk_rdata_o, model_rk[a]);
      decrypt_i = 1'b1;
      #1 check("rk_rev", rk_rdata_o, model_rk[31-a]);
    end
    decrypt_i = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ka, kb;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; key_i = '0;
    rk_addr_i = '0; decrypt_i = 1'b0;
    repeat (3) step();
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_kv", 32'(key_valid_o), 32'd0);
    check("reset_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b0;
    step();

    // Standard vector with timing and CK probes.
    run(StdKey, 33, 0, 0, 0, '0, 0);
    check("std_latency", 32'(first_done), 32'd33);
    check("std_done_cnt", 32'(done_cnt), 32'd1);
    check("std_busy_cycles", 32'(busy_cnt), 32'd32);
    check("std_kv_at1", 32'(kv_at1), 32'd0);
    check("std_kv_at_done", 32'(kv_at_done), 32'd1);
    check("ck_round1", ck_seen[1], 32'h00070e15);
    check("ck_round2", ck_seen[2], 32'h1c232a31);
    check("ck_round32", ck_seen[32], 32'h646b7279);
    step();
    check("std_idle_busy", 32'(busy_o), 32'd0);
    rk_addr_i = 5'd0; decrypt_i = 1'b0;
    #1 check("std_rk0", rk_rdata_o, 32'hf12186f9);
    rk_addr_i = 5'd31;
    #1 check("std_rk31", rk_rdata_o, 32'h9124a012);
    rk_addr_i = 5'd0; decrypt_i = 1'b1;
    #1 check("std_dec_addr0", rk_rdata_o, 32'h9124a012);
    decrypt_i = 1'b0;
    check_table(StdKey);

    // Abort outside RUN is ignored.
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    step();
    check("idle_abort_kv", 32'(key_valid_o), 32'd1);

    // Abort at RUN cycle 10, then a clean standard run.
    run(rand_key(), 14, 10, 0, 0, '0, 11);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_busy_cycles", 32'(busy_cnt), 32'd10);
    check("abort_next_cycle", 32'(snap), 32'd0);
    check("abort_kv_end", 32'(key_valid_o), 32'd0);
    run(StdKey, 33, 0, 0, 0, '0, 0);
    step();
    rk_addr_i = 5'd0; decrypt_i = 1'b0;
    #1 check("post_abort_rk0", rk_rdata_o, 32'hf12186f9);

    // Start during RUN with a different key is ignored.
    ka = rand_key();
    kb = ~ka;
    run(ka, 36, 0, 0, 5, kb, 0);
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_latency", 32'(first_done), 32'd33);
    check_table(ka);

    // Reset at RUN cycle 20, then restart.
    ka = rand_key();
    run(ka, 24, 0, 20, 0, '0, 21);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_busy_cycles", 32'(busy_cnt), 32'd20);
    check("rst_outputs", 32'(snap), 32'd0);
    run(ka, 33, 0, 0, 0, '0, 0);
    check("rst_restart_latency", 32'(first_done), 32'd33);
    check_table(ka);

    // Back-to-back: restart in the first IDLE cycle after DONE with key 0.
    run(rand_key(), 33, 0, 0, 0, '0, 0);
    check("b2b_first_done", 32'(first_done), 32'd33);
    step();
    run('0, 33, 0, 0, 0, '0, 0);
    check("b2b_kv_drop", 32'(kv_at1), 32'd0);
    check("b2b_latency", 32'(first_done), 32'd33);
    check_table('0);

    // Random keys.
    for (int n = 0; n < 3; n++) begin
      ka = rand_key();
      run(ka, 33, 0, 0, 0, '0, 0);
      check("rand_latency", 32'(first_done), 32'd33);
      check_table(ka);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sm4_key_sched_ctrl.md
# sm4_key_sched_ctrl

Sequencer for SM4 key expansion. Loads a 128-bit user key, drives the single-round key datapath `one_round_for_key_exp` (instantiated inside) for 32 consecutive cycles, and generates the CK constant and round number on the fly. The 32 round keys are stored in an internal register file and served on a combinational read port, in forward order for encryption or reverse order for decryption. Sits between the accelerator's CSR/command interface and the SM4 round pipeline.

## Interface
- No parameters; round count fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request key expansion; sampled only in IDLE.
- `abort_i`  in  1  cancel an expansion in progress.
- `key_i`  in  128  user key MK0..MK3, MK0 in [127:96]; sampled on the accepted start cycle only.
- `rk_addr_i`  in  5  round-key read index.
- `decrypt_i`  in  1  0: returns rk[addr]; 1: returns rk[31-addr].
- `rk_rdata_o`  out  32  selected round key, combinational from addr/decrypt.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse when the table completes.
- `key_valid_o`  out  1  high while the table holds a complete schedule.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `start_i`, load `state_q <= key_i`, `cnt_q <= 1`, clear `key_valid_o`, go RUN. Otherwise hold.
- RUN, per cycle: datapath inputs are `data_in = state_q`, `count_round_in = cnt_q` (6 bit), and `ck_parameter_in = CK(cnt_q-1)`. The datapath applies FK internally when the round number is 1.
  - Write `rk[cnt_q-1] <= rk_o`.
  - Update `state_q <= result_out` and `cnt_q <= cnt_q+1`.
  - After the write with `cnt_q == 32`, go DONE.
- CK(i), for i in 0..31: byte j (j=0 is the MSB) = ((4i+j)*7) mod 256. Compute with 8-bit truncating arithmetic; no ROM required.
- DONE: assert `done_o`, set `key_valid_o`, return to IDLE. Lasts one cycle.
- `abort_i` in RUN: return to IDLE next cycle. `key_valid_o` stays 0, `done_o` is not pulsed, and partially written rk entries are don't-care.
- `abort_i` outside RUN is ignored.
- `start_i` in RUN or DONE is ignored; it is not queued.
- `abort_i` and `start_i` asserted together in RUN: abort wins.
- Register file: 32x32 flops. Written only in RUN and not cleared by reset; contents are don't-care while `key_valid_o`=0.
- `rk_rdata_o` is undefined in content while `key_valid_o`=0, but must never be X-propagating after reset (mux only).

## Timing
- Reset values: FSM=IDLE, `cnt_q`=0, `state_q`=0, `busy_o`=0, `done_o`=0, `key_valid_o`=0.
- Start accepted at edge T:
  - `busy_o`=1 during cycles T+1..T+32.
  - rk[i] is written at the end of cycle T+1+i.
  - `done_o`=1 and `key_valid_o`=1 in cycle T+33, with `busy_o`=0.
  - The next start is accepted no earlier than the edge ending T+34 (FSM back in IDLE).
- Total latency from start to done: 33 cycles.
- `key_valid_o` falls in cycle T+1 of any newly accepted start.
- Reset asserted in any state overrides everything and takes effect on the next edge. There is no `done_o` pulse for an interrupted run.
- Read port has zero latency: `rk_rdata_o` follows `rk_addr_i`/`decrypt_i` in the same cycle.

## Test plan
- **Standard vector.** Key 0x0123456789abcdeffedcba9876543210, start -> `done_o` exactly 33 cycles later. Required: rk[0]=0xf12186f9 and rk[31]=0x9124a012; with `decrypt_i`=1 and addr 0, the port returns 0x9124a012.
- **CK generation.** Probe `ck_parameter_in` during the run: round 1 = 0x00070e15, round 2 = 0x1c232a31, round 32 = 0x646b7279.
- **Abort.** Assert `abort_i` at RUN cycle 10 -> IDLE on the next cycle, `key_valid_o`=0, no `done_o`. A subsequent start with the standard key gives rk[0]=0xf12186f9.
- **Ignored start.** Pulse `start_i` with a different key during RUN -> no effect: results match the original key and there is exactly one `done_o`.
- **Reset mid-operation.** Assert `rst` at RUN cycle 20 -> all outputs at reset values next cycle and no `done_o`. A later restart completes normally.
- **Back-to-back.** Start again in the first IDLE cycle after DONE with key 0 -> `key_valid_o` drops the next cycle, `done_o` after 33 cycles, and the new table differs from the previous one.
